// File: rtl/tanh_arbiter.sv
// tanh_arbiter: round-robin arbiter sharing one saturating-linear tanh unit
// (clamp to +/-1.0 in Q-format) between NUM_REQ requesters. Two registered
// stages (S1 operand, OUT result) with valid/ready on both sides sustain one
// result per cycle.
// Optional feature: define TANH_ARB_STATS_EN to build the saturation counter;
// otherwise sat_count is tied to 0.
module tanh_arbiter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRACT_WIDTH = 8,
  parameter int unsigned NUM_REQ     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [NUM_REQ-1:0]            resp_id,
  output logic                          resp_sat,
  output logic [15:0]                   sat_count
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic signed [DATA_WIDTH-1:0] PosOne = DATA_WIDTH'(1) << FRACT_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] NegOne = -PosOne;

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant;
  logic [PtrW-1:0]       grant_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] operand;

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [NUM_REQ-1:0]    s1_id_q;

  logic                  out_load;
  logic                  s1_load;
  logic [DATA_WIDTH-1:0] clamp_data;
  logic                  clamp_sat;

  assign out_load = !resp_valid | resp_ready;
  assign s1_load  = !s1_valid_q | out_load;

  // Round-robin search: first valid requester at or after ptr, with wrap-around.
  always_comb begin
    int unsigned idx;
    logic [PtrW-1:0] idx_w;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = idx[PtrW-1:0];
      if (grant == '0 && req_valid[idx_w]) begin
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
      end
    end
  end

  // Ready is masked by reset so nothing is offered while the block is held.
  assign req_ready = rst_n ? (grant & {NUM_REQ{s1_load}}) : '0;
  assign accept    = |req_ready;

  // Operand select for the granted requester.
  always_comb begin
    operand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) operand = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pointer advances past the winner only on an actual accept.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (32'(grant_idx) == NUM_REQ - 1) ptr_d = '0;
      else                               ptr_d = grant_idx + PtrW'(1);
    end
  end

  // Saturating-linear activation on the S1 operand.
  always_comb begin
    clamp_data = s1_data_q;
    clamp_sat  = 1'b0;
    if ($signed(s1_data_q) > PosOne) begin
      clamp_data = PosOne;
      clamp_sat  = 1'b1;
    end else if ($signed(s1_data_q) < NegOne) begin
      clamp_data = NegOne;
      clamp_sat  = 1'b1;
    end
  end

  // Arbiter pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Stage 1: captures the accepted operand; data held when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
    end else if (s1_load) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= operand;
        s1_id_q   <= grant;
      end
    end
  end

  // Output stage: registers the clamped result; frozen under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_sat   <= 1'b0;
    end else if (out_load) begin
      resp_valid <= s1_valid_q;
      resp_data  <= clamp_data;
      resp_id    <= s1_id_q;
      resp_sat   <= clamp_sat;
    end
  end

`ifdef TANH_ARB_STATS_EN
  logic [15:0] sat_cnt_q;

  // Count saturated results entering OUT; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (out_load && s1_valid_q && clamp_sat && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: doc/tanh_arbiter.md
# tanh_arbiter

Shares one saturating-linear tanh activation unit (Q-format, clamp to ±1.0) between `NUM_REQ` gate requesters in the GRU/LSTM cell datapath. Round-robin arbitration, valid/ready handshakes on both sides, and a two-stage registered pipeline sustain one activation per cycle. Each result is returned with the one-hot ID of the requester that issued it. The block sits between the gate accumulators and the state-update logic.

## Interface
- `DATA_WIDTH`, 16: operand/result width, signed two's complement.
- `FRACT_WIDTH`, 8: fractional bits; `ONE = 1 << FRACT_WIDTH`.
- `NUM_REQ`, 4: number of requesters, minimum 2.

- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_data`  in  NUM_REQ*DATA_WIDTH  operands, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  result consumer ready.
- `resp_data`  out  DATA_WIDTH  activation result.
- `resp_id`  out  NUM_REQ  one-hot ID of the originating requester.
- `resp_sat`  out  1  result was clamped.
- `sat_count`  out  16  saturation counter (see Configuration).

## Operation
- Activation: `y = (x > ONE) ? ONE : (x < -ONE) ? -ONE : x`, signed compare. `resp_sat = 1` exactly when clamped.
- Arbiter: round-robin pointer `ptr`, reset value 0. The grant goes to the first i with `req_valid[i]` set, searching from `ptr` upward with wrap-around.
  - `req_ready[i] = grant[i] & s1_load`.
  - Combinational from `req_valid`; `req_ready[i]` never depends on `req_data`.
  - On accept, `ptr` moves to granted index + 1, wrapping at `NUM_REQ`. With no accept, `ptr` holds.
- Stage 1 (S1) holds `s1_valid`, `s1_data`, `s1_id`.
- Output stage (OUT) holds `resp_valid`, `resp_data`, `resp_id`, `resp_sat`.
  - The clamp is computed on `s1_data` and registered into OUT.
- Advance rules:
  - `out_load = !resp_valid | resp_ready`.
  - `s1_load = !s1_valid | out_load`.
  - OUT loads S1 contents when `out_load`. `resp_valid` takes `s1_valid`.
  - S1 loads the accepted operand when `s1_load`. `s1_valid` is set only if an accept occurred.
- Reset (any time, including mid-transfer): all valids 0, `ptr` 0, `resp_data`/`resp_id`/`resp_sat` 0, `sat_count` 0. In-flight operands are dropped. `req_ready` is 0 while `rst_n` is low.
- No requests pending: pipeline drains; `ptr` unchanged.

## Timing
- Latency: operand accepted at edge k; `resp_valid` high after edge k+1 (2 cycles).
- Throughput: 1 accept/cycle while `resp_ready` is held high.
- Backpressure: with `resp_ready` low, OUT holds stable and S1 fills. Once both are full, all `req_ready` are 0. At most 2 results are in flight.
- Simultaneous `resp_ready` and accept with both stages full: OUT takes S1 and S1 takes the new operand in the same edge. No bubble, no loss.
- Output stability: OUT fields do not change while `resp_valid & !resp_ready`.
- Requesters must hold `req_valid` and `req_data` stable until accepted. Withdrawal before accept is allowed and simply reroutes the grant.

## Configuration
- `TANH_ARB_STATS_EN` defined: `sat_count` increments by 1 on each OUT load where the result saturates. It saturates at 0xFFFF and does not wrap. Reset value 0.
- Not defined: the counter logic is absent and `sat_count` is tied to 0. All other behaviour is identical.

## Test plan
- Single requester 0, `req_data` 0x0080, `resp_ready=1` -> `resp_data=0x0080`, `resp_id=0001`, `resp_sat=0`, `resp_valid` 2 cycles after accept.
- Clamp cases: 0x0300 -> 0x0100 (sat=1); 0xFD00 -> 0xFF00 (sat=1); 0x0100 -> 0x0100 (sat=0); 0xFF00 -> 0xFF00 (sat=0).
- All 4 requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and 8 results back-to-back in that ID order.
- `resp_ready` low for 3 cycles with all requesters valid -> exactly 2 accepts, then all `req_ready=0`, and OUT stable. On release, results drain in order with no loss.
- `rst_n` pulsed low while both stages are full -> `resp_valid=0` immediately. After release, the next grant goes to requester 0 and no stale results appear.
- With `TANH_ARB_STATS_EN`, send 5 saturating and 3 in-range operands -> `sat_count=5`. Without the macro, `sat_count=0`.
